// File: rtl/mem_wb_writeback.sv
// mem_wb_writeback: MIPS32 write-back stage. Registers the MEM-stage result,
// selects ALU / load / link data, and shares the single register-file write
// port between in-order pipeline writes and late multi-cycle results held in
// a 2-entry FIFO. Pipeline writes always win the port; the FIFO drains on
// cycles with no pipeline write.
module mem_wb_writeback #(
    parameter int DEPTH = 2
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        RegWrite_MEM,
    input  logic        MemtoReg_MEM,
    input  logic        Link_MEM,
    input  logic [4:0]  Write_Register_MEM,
    input  logic [31:0] ALU_Result_MEM,
    input  logic [31:0] Read_Data_MEM,
    input  logic [31:0] PC_Plus4_MEM,
    input  logic        Stall_WB,
    input  logic        Flush_WB,
    input  logic        Late_Valid,
    input  logic [4:0]  Late_Register,
    input  logic [31:0] Late_Data,
    output logic        Late_Ready,
    output logic [1:0]  Late_Pending,
    output logic [4:0]  Write_Register_WB,
    output logic [31:0] Write_Data_WB,
    output logic        RegWrite_WB
);

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_entry_t;

    wb_entry_t   queue_q [0:1];
    wb_entry_t   queue_d [0:1];
    logic [1:0]  count_q;
    logic [1:0]  count_d;

    logic        pipe_valid;
    logic [31:0] pipe_data;
    logic        push;
    logic        pop;
    wb_entry_t   late_entry;

    // Ready and pending come straight from the registered count, so they are
    // stable for the whole cycle and a full queue never sees a push.
    assign Late_Ready   = (count_q != 2'(DEPTH));
    assign Late_Pending = count_q;

    // Pipeline candidate and write-data select; link outranks load data.
    assign pipe_valid = RegWrite_MEM && (Write_Register_MEM != 5'd0) && !Flush_WB;
    assign pipe_data  = Link_MEM     ? (PC_Plus4_MEM + 32'd4) :
                        MemtoReg_MEM ? Read_Data_MEM : ALU_Result_MEM;

    // Writes to $0 are accepted from the source but never stored.
    assign push = Late_Valid && Late_Ready && (Late_Register != 5'd0);
    // The head only leaves when the port is free and the stage is not held.
    assign pop  = !Stall_WB && !pipe_valid && (count_q != 2'd0);

    assign late_entry = '{rd: Late_Register, data: Late_Data};

    // Next FIFO contents: shift on pop, then append at the post-pop tail.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        queue_d = queue_q;
        count_d = count_q + {1'b0, push} - {1'b0, pop};
        if (pop) begin
            queue_d[0] = queue_q[1];
        end
        if (push) begin
            if ((count_q - {1'b0, pop}) == 2'd0) begin
                queue_d[0] = late_entry;
            end else begin
                queue_d[1] = late_entry;
            end
        end
    end

    // Occupancy register; reset empties the queue.
    always_ff @(posedge Clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (Rst) begin
            count_q <= 2'd0;
        end else begin
            count_q <= count_d;
        end
    end

    // FIFO storage; validity is carried entirely by count_q.
    always_ff @(posedge Clk) begin
        // NOTE: entry storage is not reset; stale contents are unreachable
        // once the count is zero, so the reset fan-out is kept off the data.
        queue_q <= queue_d;
    end

    // Write-port slot: pipeline first, then queue head, else idle with the
    // address/data held; a stall freezes everything.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            RegWrite_WB       <= 1'b0;
            Write_Register_WB <= 5'd0;
            Write_Data_WB     <= 32'd0;
        end else if (!Stall_WB) begin
            if (pipe_valid) begin
                RegWrite_WB       <= 1'b1;
                Write_Register_WB <= Write_Register_MEM;
                Write_Data_WB     <= pipe_data;
            end else if (pop) begin
                RegWrite_WB       <= 1'b1;
                Write_Register_WB <= queue_q[0].rd;
                Write_Data_WB     <= queue_q[0].data;
            end else begin
                RegWrite_WB       <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_wb_writeback.sv
// Testbench for mem_wb_writeback. Stimulus pushes the expected register-file
// writes, in order, into a scoreboard; a monitor on the falling edge pops and
// compares every new write the DUT presents. Status outputs are checked
// directly at fixed points.
module tb_mem_wb_writeback;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        RegWrite_MEM, MemtoReg_MEM, Link_MEM;
    logic [4:0]  Write_Register_MEM;
    logic [31:0] ALU_Result_MEM, Read_Data_MEM, PC_Plus4_MEM;
    logic        Stall_WB, Flush_WB;
    logic        Late_Valid;
    logic [4:0]  Late_Register;
    logic [31:0] Late_Data;
    logic        Late_Ready;
    logic [1:0]  Late_Pending;
    logic [4:0]  Write_Register_WB;
    logic [31:0] Write_Data_WB;
    logic        RegWrite_WB;

    int checks   = 0;
    int failures = 0;

    logic [36:0] sb[$];
    logic        edge_stall;
    logic        edge_rst;

    mem_wb_writeback #(.DEPTH(2)) dut (
        .Clk(Clk), .Rst(Rst),
        .RegWrite_MEM(RegWrite_MEM), .MemtoReg_MEM(MemtoReg_MEM), .Link_MEM(Link_MEM),
        .Write_Register_MEM(Write_Register_MEM), .ALU_Result_MEM(ALU_Result_MEM),
        .Read_Data_MEM(Read_Data_MEM), .PC_Plus4_MEM(PC_Plus4_MEM),
        .Stall_WB(Stall_WB), .Flush_WB(Flush_WB),
        .Late_Valid(Late_Valid), .Late_Register(Late_Register), .Late_Data(Late_Data),
        .Late_Ready(Late_Ready), .Late_Pending(Late_Pending),
        .Write_Register_WB(Write_Register_WB), .Write_Data_WB(Write_Data_WB),
        .RegWrite_WB(RegWrite_WB)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic expect_wr(input logic [4:0] r, input logic [31:0] d);
        sb.push_back({r, d});
    endtask

    // One clock edge; returns 1 time unit after it so outputs are settled.
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic pipe(input logic rw, input logic mtr, input logic lnk,
                        input logic [4:0] r, input logic [31:0] alu);
        RegWrite_MEM       = rw;
        MemtoReg_MEM       = mtr;
        Link_MEM           = lnk;
        Write_Register_MEM = r;
        ALU_Result_MEM     = alu;
    endtask

    task automatic late(input logic v, input logic [4:0] r, input logic [31:0] d);
        Late_Valid    = v;
        Late_Register = r;
        Late_Data     = d;
    endtask

    // Record the control state each edge used, so held (stalled) writes are
    // not counted as new ones.
    always @(posedge Clk) begin
        edge_stall = Stall_WB;
        edge_rst   = Rst;
    end

    // Monitor: every new write must match the scoreboard head.
    always @(negedge Clk) begin
        logic [36:0] exp_e;
        if (!edge_stall && !edge_rst && RegWrite_WB === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_write_reg", {27'd0, Write_Register_WB}, 32'hFFFF_FFFF);
            end else begin
                exp_e = sb.pop_front();
                check("wb_reg",  {27'd0, Write_Register_WB}, {27'd0, exp_e[36:32]});
                check("wb_data", Write_Data_WB, exp_e[31:0]);
            end
        end
    end

    initial begin
        Rst = 1'b1;
        Stall_WB = 1'b0;
        Flush_WB = 1'b0;
        Read_Data_MEM = 32'h22;
        PC_Plus4_MEM  = 32'h400;
        pipe(1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        late(1'b1, 5'd7, 32'h7777_7777);

        // Reset held two cycles with a late result offered.
        step();
        step();
        check("rst_regwrite", {31'd0, RegWrite_WB}, 32'd0);
        check("rst_wreg", {27'd0, Write_Register_WB}, 32'd0);
        check("rst_wdata", Write_Data_WB, 32'd0);
        check("rst_pending", {30'd0, Late_Pending}, 32'd0);
        check("rst_ready", {31'd0, Late_Ready}, 32'd1);
        Rst = 1'b0;
        late(1'b0, 5'd0, 32'h0);
        step();
        check("idle_regwrite", {31'd0, RegWrite_WB}, 32'd0);

        // Data select to $5.
        pipe(1'b1, 1'b0, 1'b0, 5'd5, 32'h11); expect_wr(5'd5, 32'h11);  step();
        pipe(1'b1, 1'b1, 1'b0, 5'd5, 32'h11); expect_wr(5'd5, 32'h22);  step();
        pipe(1'b1, 1'b1, 1'b1, 5'd5, 32'h11); expect_wr(5'd5, 32'h404); step();
        pipe(1'b1, 1'b0, 1'b1, 5'd5, 32'h11); expect_wr(5'd5, 32'h404); step();
        pipe(1'b1, 1'b0, 1'b0, 5'd0, 32'h11); step();
        check("r0_regwrite", {31'd0, RegWrite_WB}, 32'd0);
        check("r0_hold_reg", {27'd0, Write_Register_WB}, 32'd5);
        check("r0_hold_data", Write_Data_WB, 32'h404);

        // Late result waits behind three pipeline writes to $3.
        pipe(1'b1, 1'b0, 1'b0, 5'd3, 32'h33);
        late(1'b1, 5'd9, 32'hDEAD);
        expect_wr(5'd3, 32'h33); expect_wr(5'd3, 32'h33); expect_wr(5'd3, 32'h33);
        expect_wr(5'd9, 32'hDEAD);
        step();
        late(1'b0, 5'd0, 32'h0);
        check("arb_pending1", {30'd0, Late_Pending}, 32'd1);
        step();
        step();
        check("arb_pending_held", {30'd0, Late_Pending}, 32'd1);
        pipe(1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        step();
        check("arb_pending0", {30'd0, Late_Pending}, 32'd0);
        check("arb_late_reg", {27'd0, Write_Register_WB}, 32'd9);
        step();
        check("arb_idle", {31'd0, RegWrite_WB}, 32'd0);

        // Queue full under continuous pipeline writes, then FIFO drain.
        pipe(1'b1, 1'b0, 1'b0, 5'd4, 32'h44);
        expect_wr(5'd4, 32'h44); expect_wr(5'd4, 32'h44); expect_wr(5'd4, 32'h44);
        expect_wr(5'd10, 32'hA1); expect_wr(5'd11, 32'hB2); expect_wr(5'd12, 32'hC3);
        late(1'b1, 5'd10, 32'hA1); step();
        late(1'b1, 5'd11, 32'hB2); step();
        check("full_pending2", {30'd0, Late_Pending}, 32'd2);
        check("full_ready0", {31'd0, Late_Ready}, 32'd0);
        late(1'b1, 5'd12, 32'hC3); step();
        check("full_c_held", {30'd0, Late_Pending}, 32'd2);
        pipe(1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        step();
        check("drain_pending1", {30'd0, Late_Pending}, 32'd1);
        check("drain_ready1", {31'd0, Late_Ready}, 32'd1);
        step();
        late(1'b0, 5'd0, 32'h0);
        check("pushpop_pending1", {30'd0, Late_Pending}, 32'd1);
        step();
        check("drain_pending0", {30'd0, Late_Pending}, 32'd0);
        step();

        // Stall and flush.
        pipe(1'b1, 1'b0, 1'b0, 5'd6, 32'h66);
        late(1'b1, 5'd13, 32'hD13);
        expect_wr(5'd6, 32'h66);
        step();
        late(1'b1, 5'd14, 32'hE14);
        Stall_WB = 1'b1;
        step();
        late(1'b0, 5'd0, 32'h0);
        check("stall_push_pending", {30'd0, Late_Pending}, 32'd2);
        step();
        check("stall_hold_we", {31'd0, RegWrite_WB}, 32'd1);
        check("stall_hold_reg", {27'd0, Write_Register_WB}, 32'd6);
        check("stall_hold_data", Write_Data_WB, 32'h66);
        check("stall_no_pop", {30'd0, Late_Pending}, 32'd2);
        Stall_WB = 1'b0;
        Flush_WB = 1'b1;
        pipe(1'b1, 1'b0, 1'b0, 5'd6, 32'h77);
        expect_wr(5'd13, 32'hD13);
        step();
        check("flush_pop_pending", {30'd0, Late_Pending}, 32'd1);
        Stall_WB = 1'b1;
        step();
        check("stallflush_reg", {27'd0, Write_Register_WB}, 32'd13);
        check("stallflush_pending", {30'd0, Late_Pending}, 32'd1);
        Stall_WB = 1'b0;
        Flush_WB = 1'b0;
        pipe(1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        expect_wr(5'd14, 32'hE14);
        step();
        check("after_stall_pending", {30'd0, Late_Pending}, 32'd0);
        step();

        // Reset while two entries are queued: neither may ever be written.
        pipe(1'b1, 1'b0, 1'b0, 5'd8, 32'h88);
        expect_wr(5'd8, 32'h88); expect_wr(5'd8, 32'h88);
        late(1'b1, 5'd15, 32'hF15); step();
        late(1'b1, 5'd16, 32'hF16); step();
        check("prerst_pending", {30'd0, Late_Pending}, 32'd2);
        late(1'b0, 5'd0, 32'h0);
        pipe(1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        Rst = 1'b1;
        step();
        check("mid_rst_we", {31'd0, RegWrite_WB}, 32'd0);
        check("mid_rst_reg", {27'd0, Write_Register_WB}, 32'd0);
        check("mid_rst_pending", {30'd0, Late_Pending}, 32'd0);
        check("mid_rst_ready", {31'd0, Late_Ready}, 32'd1);
        Rst = 1'b0;
        for (int i = 0; i < 5; i++) step();
        check("post_rst_we", {31'd0, RegWrite_WB}, 32'd0);

        check("sb_drained", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
